// File: rtl/conv11_output_writer_if.sv
// Bundle between the conv11 output writer, the layer controller, the result buffer
// and the downstream byte stream. master = writer side, slave = environment side.
interface conv11_output_writer_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned ACC_W  = 32
);
   logic              output_start;
   logic              output_done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [ACC_W-1:0]  rd_data;
   logic [7:0]        m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (
      input  output_start, rd_data, m_ready,
      output output_done, rd_en, rd_addr, m_data, m_valid, m_last
   );

   modport slave (
      output output_start, rd_data, m_ready,
      input  output_done, rd_en, rd_addr, m_data, m_valid, m_last
   );
endinterface

// File: rtl/conv11_output_writer.sv
// conv11 output stage: reads N_OUT accumulators, applies ReLU + shift + u8 saturation,
// streams the bytes out and pulses output_done after the last accepted byte.
module conv11_output_writer #(
   parameter int unsigned N_OUT  = 64,
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned SHIFT  = 8
) (
   input logic                    clk,
   input logic                    rst,
   conv11_output_writer_if.master if_wr
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_OUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SEND,
      S_DONE,
      S_HOLD
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_en;
   logic              r_m_valid;
   logic [7:0]        r_m_data;
   logic              r_m_last;
   logic              r_done;

   wire               w_start     = if_wr.output_start;
   wire               w_accept    = r_m_valid & if_wr.m_ready;
   wire               w_is_last   = (r_idx == LAST_IDX);
   wire               w_in_run    = (r_state == S_READ) || (r_state == S_WAIT) ||
                                    (r_state == S_SEND);

   // ReLU, arithmetic shift (operand is non-negative once ReLU passes) and u8 clamp
   function automatic logic [7:0] quant(input logic [ACC_W-1:0] x);
      logic [ACC_W-1:0] v;
      logic [7:0]       q;
      v = x >> SHIFT;
      if (x[ACC_W-1])
         q = 8'd0;
      else if (v > ACC_W'(255))
         q = 8'hFF;
      else
         q = v[7:0];
      return q;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_rd_addr <= '0;
         r_rd_en   <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_data  <= 8'd0;
         r_m_last  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
         if (w_in_run && !w_start) begin
            // Controller withdrew the request: drop the run, nothing counts as delivered
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_start) begin
                     r_state   <= S_READ;
                     r_idx     <= '0;
                     r_rd_addr <= '0;
                     r_rd_en   <= 1'b1;
                  end
               end
               S_READ: r_state <= S_WAIT;
               S_WAIT: begin
                  r_m_data  <= quant(if_wr.rd_data);
                  r_m_last  <= w_is_last;
                  r_m_valid <= 1'b1;
                  r_state   <= S_SEND;
               end
               S_SEND: begin
                  if (w_accept) begin
                     r_m_valid <= 1'b0;
                     r_m_last  <= 1'b0;
                     if (w_is_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_idx     <= r_idx + ADDR_W'(1);
                        r_rd_addr <= r_idx + ADDR_W'(1);
                        r_rd_en   <= 1'b1;
                        r_state   <= S_READ;
                     end
                  end
               end
               S_DONE: r_state <= S_HOLD;
               S_HOLD: begin
                  if (!w_start) r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign if_wr.output_done = r_done;
   assign if_wr.rd_en       = r_rd_en;
   assign if_wr.rd_addr     = r_rd_addr;
   assign if_wr.m_valid     = r_m_valid;
   assign if_wr.m_data      = r_m_data;
   assign if_wr.m_last      = r_m_last;

endmodule

// File: tb/tb_conv11_output_writer.sv
// Scoreboard bench for conv11_output_writer (N_OUT=4, SHIFT=8): expected bytes and
// read addresses are queued by the stimulus and popped by an independent monitor.
module tb_conv11_output_writer;

   localparam int unsigned N_OUT  = 4;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned ACC_W  = 32;
   localparam int unsigned SHIFT  = 8;
   localparam int          BUDGET = 300;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   conv11_output_writer_if #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus ();

   conv11_output_writer #(
      .N_OUT(N_OUT), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .if_wr(bus.master)
   );

   logic [31:0] mem [8];
   logic [8:0]  exp_q [$];
   logic [ADDR_W-1:0] addr_q [$];
   int n_chk = 0, n_pass = 0, n_fail = 0;
   int done_cnt = 0, exp_done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference quantizer: plain signed arithmetic
   function automatic logic [7:0] ref_q(input logic [31:0] x);
      longint v;
      v = longint'($signed(x));
      if (v < 0) return 8'd0;
      v = v / (longint'(1) << SHIFT);
      if (v > 255) return 8'hFF;
      return 8'(v);
   endfunction

   // Result-buffer model: data valid one cycle after rd_en, garbage otherwise
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
      else           bus.rd_data <= $urandom;
   end

   // Monitor
   logic       p_valid = 0, p_ready = 0, p_start = 0, p_rst = 0, p_done = 0;
   logic [8:0] p_byte  = '0;
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst) begin
         if (bus.m_valid && bus.m_ready && bus.output_start) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", 64'({bus.m_last, bus.m_data}), 64'h1FF);
            end else begin
               e = exp_q.pop_front();
               chk("byte_data", 64'(bus.m_data), 64'(e[7:0]));
               chk("byte_last", 64'(bus.m_last), 64'(e[8]));
            end
         end
         if (bus.rd_en) begin
            chk("rd_while_valid", 64'(bus.m_valid), 64'd0);
            if (addr_q.size() == 0) chk("unexpected_rd_en", 64'(bus.rd_addr), 64'hFF);
            else                    chk("rd_addr", 64'(bus.rd_addr), 64'(addr_q.pop_front()));
         end
         if (p_rst && p_valid && !p_ready && p_start)
            chk("stall_stable", 64'({bus.m_valid, bus.m_last, bus.m_data}), 64'({1'b1, p_byte}));
         if (bus.output_done) begin
            done_cnt++;
            chk("done_width", 64'(p_done), 64'd0);
         end
      end
      p_valid = bus.m_valid;
      p_ready = bus.m_ready;
      p_start = bus.output_start;
      p_rst   = rst;
      p_done  = bus.output_done;
      p_byte  = {bus.m_last, bus.m_data};
   end

   function automatic logic rdy(input int mode, input int c);
      case (mode)
         1:       return !(c >= 6 && c <= 10);
         2:       return ($urandom_range(0, 3) != 0);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000FF80;
         1: return 32'h00010000;
         2: return 32'h000000FF;
         3: return 32'h80000000;
         4: return 32'h0000FEFF;
         5: return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   // One run; n_bytes/n_rd are the bytes and reads expected before any abort
   task automatic do_run(input int mode, input int abort_cyc, input int exp_done,
                         input int hold, input int n_bytes, input int n_rd);
      int c = 0, done_at = 0;
      for (int k = 0; k < n_bytes; k++) exp_q.push_back({k == N_OUT - 1, ref_q(mem[k])});
      for (int k = 0; k < n_rd; k++) addr_q.push_back(ADDR_W'(k));
      if (abort_cyc == 0) exp_done_cnt++;
      @(posedge clk); #1;
      bus.output_start = 1'b1;
      while (1) begin
         @(posedge clk); #1;
         c++;
         bus.m_ready = rdy(mode, c);
         if (abort_cyc != 0 && c == abort_cyc) bus.output_start = 1'b0;
         if (done_at != 0 && c == done_at + hold + 1) bus.output_start = 1'b0;
         @(negedge clk);
         if (bus.output_done && done_at == 0) done_at = c;
         if (abort_cyc != 0 && c == abort_cyc + 1) chk("abort_valid_drop", 64'(bus.m_valid), 64'd0);
         if (abort_cyc != 0 && c == abort_cyc + 8) break;
         if (done_at != 0 && c == done_at + hold + 3) break;
         if (c > BUDGET) begin
            n_chk++; n_fail++;
            $display("FAIL run_timeout: no output_done within %0d cycles", BUDGET);
            break;
         end
      end
      bus.output_start = 1'b0;
      bus.m_ready      = 1'b1;
      if (abort_cyc != 0) chk("abort_no_done", 64'(done_at), 64'd0);
      else if (exp_done != 0) chk("done_cycle", 64'(done_at), 64'(exp_done));
      chk("bytes_drained", 64'(exp_q.size()), 64'd0);
      chk("reads_drained", 64'(addr_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      bus.output_start = 1'b0;
      bus.m_ready      = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({bus.output_done, bus.rd_en, bus.rd_addr, bus.m_valid,
                                bus.m_data, bus.m_last}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      bus.m_ready = 1'b1;

      // Basic run
      mem[0] = 32'h00000100; mem[1] = 32'h00002A00; mem[2] = 32'hFFFFFF00; mem[3] = 32'h7FFFFFFF;
      chk("ref_basic", 64'({ref_q(mem[0]), ref_q(mem[1]), ref_q(mem[2]), ref_q(mem[3])}),
          64'h012A00FF);
      do_run(0, 0, 13, 0, 4, 4);

      // Backpressure on byte 1
      do_run(1, 0, 18, 0, 4, 4);

      // Saturation / ReLU boundaries
      mem[0] = 32'h0000FF80; mem[1] = 32'h00010000; mem[2] = 32'h000000FF; mem[3] = 32'h80000000;
      do_run(0, 0, 13, 0, 4, 4);
      mem[0] = 32'h0000FFFF; mem[1] = 32'h0000FEFF; mem[2] = 32'h00000000; mem[3] = 32'h00FFFFFF;
      do_run(0, 0, 13, 0, 4, 4);

      // Re-arm: start held past done, then a fresh run from address 0
      do_run(0, 0, 13, 3, 4, 4);
      do_run(0, 0, 13, 0, 4, 4);

      // Abort while byte 2 is in SEND (cycle 9); byte 2 counts as undelivered
      do_run(0, 9, 0, 0, 2, 3);
      do_run(0, 0, 13, 0, 4, 4);

      // Reset for one cycle during WAIT
      addr_q.push_back('0);
      @(posedge clk); #1; bus.output_start = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1; rst = 1'b1; bus.output_start = 1'b0;
      @(negedge clk);
      chk("midrun_reset_outputs", 64'({bus.output_done, bus.rd_en, bus.rd_addr, bus.m_valid,
                                       bus.m_data, bus.m_last}), 64'd0);
      do_run(0, 0, 13, 0, 4, 4);

      // Randomized data and backpressure
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++) mem[i] = rnd_val();
         do_run(2, 0, 0, $urandom_range(0, 2), 4, 4);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("done_count", 64'(done_cnt), 64'(exp_done_cnt));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
